// File: rtl/branch_resolve_unit_if.sv
// Bundle between fetch (push), execute (resolve) and the branch resolution unit,
// which in turn drives the predictor update/flush side.
interface branch_resolve_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  fq_push_valid;
   logic [ADDR_WIDTH-1:0] fq_push_pc;
   logic                  fq_push_taken;
   logic [ADDR_WIDTH-1:0] fq_push_target;
   logic                  fq_full;

   logic                  ex_valid;
   logic [ADDR_WIDTH-1:0] ex_pc;
   logic                  ex_taken;
   logic [ADDR_WIDTH-1:0] ex_target;
   logic                  ex_call;
   logic                  ex_ret;

   logic                  bpu_valid;
   logic                  bpu_flush;
   logic [ADDR_WIDTH-1:0] bpu_pc;
   logic [ADDR_WIDTH-1:0] bpu_target;
   logic                  bpu_taken;
   logic                  bpu_call;
   logic                  bpu_ret;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [31:0]           cnt_branch;
   logic [31:0]           cnt_mispred;

   modport master (
      output fq_push_valid, fq_push_pc, fq_push_taken, fq_push_target,
      output ex_valid, ex_pc, ex_taken, ex_target, ex_call, ex_ret,
      input  fq_full, bpu_valid, bpu_flush, bpu_pc, bpu_target, bpu_taken,
      input  bpu_call, bpu_ret, redirect_pc, cnt_branch, cnt_mispred
   );

   modport slave (
      input  fq_push_valid, fq_push_pc, fq_push_taken, fq_push_target,
      input  ex_valid, ex_pc, ex_taken, ex_target, ex_call, ex_ret,
      output fq_full, bpu_valid, bpu_flush, bpu_pc, bpu_target, bpu_taken,
      output bpu_call, bpu_ret, redirect_pc, cnt_branch, cnt_mispred
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Back-end branch resolution: in-order prediction FIFO checked against execute
// outcomes, producing predictor updates, mispredict flushes and fetch redirects.
module branch_resolve_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int FQ_DEPTH   = 8,
   parameter int FQ_AW      = 3,
   parameter int FLUSH_HOLD = 2
) (
   input logic                  CLK,
   input logic                  RST,
   branch_resolve_unit_if.slave bus
);
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  taken;
      logic [ADDR_WIDTH-1:0] target;
   } fq_ent_t;

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [FQ_AW:0] FULL_CNT = (FQ_AW+1)'(FQ_DEPTH);

   fq_ent_t          fq_mem [FQ_DEPTH];
   logic [FQ_AW-1:0] rd_ptr, wr_ptr;
   logic [FQ_AW:0]   fq_cnt;
   logic [3:0]       hold_cnt;
   state_t           state;

   fq_ent_t head;
   logic    fq_empty, res, mis, push, pop;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   assign fq_empty    = (fq_cnt == '0);
   assign bus.fq_full = (fq_cnt == FULL_CNT);
   assign head        = fq_mem[rd_ptr];
   assign res         = (state == RUN) & bus.ex_valid;
   // An empty FIFO on resolve means fetch never predicted this instruction.
   assign mis  = res & (fq_empty | (head.pc != bus.ex_pc) | (head.taken != bus.ex_taken) |
                        (bus.ex_taken & (head.target != bus.ex_target)));
   // Full uses the pre-edge count: a push at full is dropped even with a pop.
   assign push = (state == RUN) & bus.fq_push_valid & ~bus.fq_full & ~mis;
   assign pop  = res & ~fq_empty;

   always_ff @(posedge CLK) begin
      if (push) fq_mem[wr_ptr] <= fq_ent_t'{pc: bus.fq_push_pc, taken: bus.fq_push_taken,
                                           target: bus.fq_push_target};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state           <= RUN;
         hold_cnt        <= '0;
         fq_cnt          <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         bus.bpu_valid   <= 1'b0;
         bus.bpu_flush   <= 1'b0;
         bus.bpu_pc      <= '0;
         bus.bpu_target  <= '0;
         bus.bpu_taken   <= 1'b0;
         bus.bpu_call    <= 1'b0;
         bus.bpu_ret     <= 1'b0;
         bus.redirect_pc <= '0;
         bus.cnt_branch  <= '0;
         bus.cnt_mispred <= '0;
      end else begin
         bus.bpu_valid <= res;
         bus.bpu_flush <= mis;
         if (res) begin
            bus.bpu_pc      <= bus.ex_pc;
            bus.bpu_target  <= bus.ex_target;
            bus.bpu_taken   <= bus.ex_taken;
            bus.bpu_call    <= bus.ex_call;
            bus.bpu_ret     <= bus.ex_ret;
            bus.redirect_pc <= bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_WIDTH'(4);
            bus.cnt_branch  <= sat_inc(bus.cnt_branch);
            if (mis) bus.cnt_mispred <= sat_inc(bus.cnt_mispred);
         end

         if (mis) begin
            fq_cnt   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            state    <= HOLD;
            hold_cnt <= 4'(FLUSH_HOLD);
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - 4'd1;
            if (hold_cnt == 4'd1) state <= RUN;
         end else begin
            if (push) wr_ptr <= wr_ptr + FQ_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FQ_AW'(1);
            case ({push, pop})
               2'b10:   fq_cnt <= fq_cnt + (FQ_AW+1)'(1);
               2'b01:   fq_cnt <= fq_cnt - (FQ_AW+1)'(1);
               default: fq_cnt <= fq_cnt;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   branch_resolve_unit_if #(.ADDR_WIDTH(32)) bus ();

   branch_resolve_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // One clock with the given inputs, then inputs return to idle.
   task automatic drv(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic ev, input logic [31:0] epc,
                      input logic et, input logic [31:0] etg, input logic ec, input logic er);
      bus.fq_push_valid = pv;  bus.fq_push_pc = ppc; bus.fq_push_taken = pt;
      bus.fq_push_target = ptg;
      bus.ex_valid = ev; bus.ex_pc = epc; bus.ex_taken = et; bus.ex_target = etg;
      bus.ex_call = ec; bus.ex_ret = er;
      @(posedge CLK); #1;
      bus.fq_push_valid = 1'b0; bus.ex_valid = 1'b0;
      bus.ex_call = 1'b0; bus.ex_ret = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
      drv(1, pc, t, tg, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
      drv(0, 0, 0, 0, 1, pc, t, tg, 0, 0);
   endtask

   function automatic logic [31:0] e_pc(input int k);  return 32'h1000 + 32'(4*k); endfunction
   function automatic logic        e_tk(input int k);  return k[0];                 endfunction
   function automatic logic [31:0] e_tg(input int k);  return 32'h3000 + 32'(8*k); endfunction
   function automatic logic [31:0] e_rd(input int k);
      return e_tk(k) ? e_tg(k) : e_pc(k) + 32'd4;
   endfunction

   initial begin
      bus.fq_push_pc = '0; bus.fq_push_taken = 1'b0; bus.fq_push_target = '0;
      bus.ex_pc = '0; bus.ex_taken = 1'b0; bus.ex_target = '0;

      // Reset
      RST = 1'b1;
      idle(2);
      chk("rst_valid",   bus.bpu_valid, 0);
      chk("rst_flush",   bus.bpu_flush, 0);
      chk("rst_pc",      bus.bpu_pc, 0);
      chk("rst_redir",   bus.redirect_pc, 0);
      chk("rst_full",    bus.fq_full, 0);
      chk("rst_cnt_br",  bus.cnt_branch, 0);
      chk("rst_cnt_mp",  bus.cnt_mispred, 0);
      RST = 1'b0;

      // Correct prediction (a call)
      push(32'h100, 1, 32'h200);
      drv(0, 0, 0, 0, 1, 32'h100, 1, 32'h200, 1, 0);
      chk("ok_valid",  bus.bpu_valid, 1);
      chk("ok_flush",  bus.bpu_flush, 0);
      chk("ok_call",   bus.bpu_call, 1);
      chk("ok_redir",  bus.redirect_pc, 32'h200);
      chk("ok_cnt_br", bus.cnt_branch, 1);
      idle(1);
      chk("idle_valid", bus.bpu_valid, 0);
      chk("idle_pc",    bus.bpu_pc, 32'h100);

      // Direction mispredict, then HOLD ignores inputs
      push(32'h100, 0, 32'h0);
      resolve(32'h100, 1, 32'h300);
      chk("dir_flush",  bus.bpu_flush, 1);
      chk("dir_redir",  bus.redirect_pc, 32'h300);
      chk("dir_cnt_mp", bus.cnt_mispred, 1);
      chk("dir_cnt_br", bus.cnt_branch, 2);
      drv(1, 32'h500, 1, 32'h600, 1, 32'h500, 1, 32'h600, 0, 0);
      chk("hold_valid",  bus.bpu_valid, 0);
      chk("hold_cnt_br", bus.cnt_branch, 2);
      push(32'h700, 1, 32'h800);
      resolve(32'h700, 1, 32'h800);   // push during HOLD was ignored -> empty
      chk("hold_push_drop", bus.bpu_flush, 1);
      chk("hold_cnt_mp",    bus.cnt_mispred, 2);
      idle(2);
      push(32'h40, 1, 32'h44);        // first RUN cycle after exactly two HOLD cycles
      resolve(32'h40, 1, 32'h44);
      chk("hold_len_flush", bus.bpu_flush, 0);
      chk("hold_len_valid", bus.bpu_valid, 1);

      // Not-taken mispredict (a return), redirect to fall-through
      push(32'h1FC, 1, 32'h80);
      drv(0, 0, 0, 0, 1, 32'h1FC, 0, 32'h80, 0, 1);
      chk("nt_flush", bus.bpu_flush, 1);
      chk("nt_redir", bus.redirect_pc, 32'h200);
      chk("nt_taken", bus.bpu_taken, 0);
      chk("nt_ret",   bus.bpu_ret, 1);
      chk("nt_cnt_mp", bus.cnt_mispred, 3);
      idle(2);

      // Fill, overflow, pop at full with push, wrap
      for (int k = 0; k < 8; k++) begin
         chk("fill_nfull", bus.fq_full, 0);
         push(e_pc(k), e_tk(k), e_tg(k));
      end
      chk("fill_full", bus.fq_full, 1);
      push(32'hDEAD0, 1, 32'hBEEF0);
      chk("ovf_full", bus.fq_full, 1);
      drv(1, 32'hDEAD4, 1, 32'hBEEF4, 1, e_pc(0), e_tk(0), e_tg(0), 0, 0);
      chk("popfull_flush", bus.bpu_flush, 0);
      chk("popfull_nfull", bus.fq_full, 0);
      for (int j = 0; j < 20; j++) begin
         drv(1, e_pc(8+j), e_tk(8+j), e_tg(8+j), 1, e_pc(1+j), e_tk(1+j), e_tg(1+j), 0, 0);
         chk("pair_flush", bus.bpu_flush, 0);
         chk("pair_pc",    bus.bpu_pc, e_pc(1+j));
         chk("pair_redir", bus.redirect_pc, e_rd(1+j));
      end
      chk("pair_nfull", bus.fq_full, 0);
      for (int k = 21; k < 28; k++) begin
         resolve(e_pc(k), e_tk(k), e_tg(k));
         chk("drain_flush", bus.bpu_flush, 0);
         chk("drain_pc",    bus.bpu_pc, e_pc(k));
      end
      chk("wrap_cnt_br", bus.cnt_branch, 33);
      chk("wrap_cnt_mp", bus.cnt_mispred, 3);

      // Empty resolve with same-cycle push
      drv(1, 32'h500, 1, 32'h600, 1, 32'h500, 1, 32'h600, 0, 0);
      chk("empty_flush", bus.bpu_flush, 1);
      chk("empty_redir", bus.redirect_pc, 32'h600);
      idle(2);
      resolve(32'h500, 1, 32'h600);
      chk("empty_push_drop", bus.bpu_flush, 1);
      chk("empty_cnt_br",    bus.cnt_branch, 35);
      chk("empty_cnt_mp",    bus.cnt_mispred, 5);

      // Reset during HOLD returns straight to RUN
      RST = 1'b1;
      idle(1);
      RST = 1'b0;
      chk("rrst_flush",  bus.bpu_flush, 0);
      chk("rrst_cnt_mp", bus.cnt_mispred, 0);
      chk("rrst_redir",  bus.redirect_pc, 0);
      push(32'h900, 0, 32'h0);
      resolve(32'h900, 0, 32'h0);
      chk("rrst_flush2", bus.bpu_flush, 0);
      chk("rrst_redir2", bus.redirect_pc, 32'h904);
      chk("rrst_cnt_br", bus.cnt_branch, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end
endmodule
